// File: rtl/key_input_conditioner_if.sv
`default_nettype none
// ============================================================================
// key_input_conditioner_if
// ----------------------------------------------------------------------------
// Bundles the raw push-button inputs and the conditioned command outputs of
// the key input conditioner.
//
//   key_up/down/right/left/place  raw active-high key levels (async, bouncing)
//   dir                           3-bit one-cycle direction command
//   move                          one-cycle place strobe
//   keys_stable                   debounced levels {place,left,right,down,up}
//
// master : the side that drives the keys and consumes the commands
// slave  : the conditioner itself
//
// Revision: 1.0 - initial release
// ============================================================================
interface key_input_conditioner_if;
  logic       key_up;
  logic       key_down;
  logic       key_right;
  logic       key_left;
  logic       key_place;
  logic [2:0] dir;
  logic       move;
  logic [4:0] keys_stable;

  modport master (
    output key_up, key_down, key_right, key_left, key_place,
    input  dir, move, keys_stable
  );

  modport slave (
    input  key_up, key_down, key_right, key_left, key_place,
    output dir, move, keys_stable
  );
endinterface
`default_nettype wire

// File: rtl/key_input_conditioner.sv
`default_nettype none
// ============================================================================
// key_input_conditioner
// ----------------------------------------------------------------------------
// Front end of the tic-tac-toe cursor logic. Each raw key is synchronised
// (two flops) and debounced; 0->1 transitions of the debounced levels become
// press events. Direction presses are arbitrated (Up > Down > Right > Left)
// and drive an auto-repeat state machine; the place key yields a single
// move strobe per press.
//
// Ports:
//   clk     system clock, rising edge
//   resetn  synchronous, active-low reset
//   bus     slave modport of key_input_conditioner_if
//             in : key_up, key_down, key_right, key_left, key_place
//             out: dir (000 idle, 001 up, 010 down, 011 right, 100 left),
//                  move, keys_stable {place,left,right,down,up}
//
// Revision: 1.0 - initial release
// ============================================================================
module key_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 10000000,
  parameter int CNT_W           = 25
) (
  input wire                     clk,
  input wire                     resetn,
  key_input_conditioner_if.slave bus
);

  // Terminal counts: a counter value equal to these marks the last cycle of
  // the interval, so the action happens on the cycle the count would reach
  // the full parameter value.
  localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(REPEAT_PERIOD - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } state_t;

  // Bit order everywhere: {place, left, right, down, up}
  logic [4:0] raw_keys;
  logic [4:0] sync_a;
  logic [4:0] sync_b;
  logic [4:0] stable;
  logic [4:0] stable_d;
  logic [4:0] press;

  logic       dir_hit;
  logic [1:0] dir_sel;

  state_t           state;
  logic [1:0]       active;
  logic [CNT_W-1:0] rep_cnt;
  logic [2:0]       dir_q;
  logic             move_q;
  logic             active_held;

  assign raw_keys = {bus.key_place, bus.key_left, bus.key_right,
                     bus.key_down, bus.key_up};

  // Index 0..3 (up, down, right, left) maps to command codes 1..4.
  function automatic logic [2:0] dir_code(input logic [1:0] idx);
    return {1'b0, idx} + 3'd1;
  endfunction

  // --------------------------------------------------------------------------
  // Two-flop synchronisers, plus a delayed copy of the stable levels used
  // for rising-edge (press) detection.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!resetn) begin
      sync_a   <= 5'd0;
      sync_b   <= 5'd0;
      stable_d <= 5'd0;
    end else begin
      sync_a   <= raw_keys;
      sync_b   <= sync_a;
      stable_d <= stable;
    end
  end

  // --------------------------------------------------------------------------
  // Per-key debounce: the stable level only follows the synchronised level
  // after it has disagreed for DEBOUNCE_CYCLES consecutive cycles. Any
  // agreement in between restarts the count.
  // --------------------------------------------------------------------------
  for (genvar i = 0; i < 5; i++) begin : g_debounce
    logic [CNT_W-1:0] cnt;
    logic             level;

    always_ff @(posedge clk) begin
      if (!resetn) begin
        cnt   <= '0;
        level <= 1'b0;
      end else if (sync_b[i] == level) begin
        cnt <= '0;
      end else if (cnt == DB_LAST) begin
        level <= sync_b[i];
        cnt   <= '0;
      end else begin
        cnt <= cnt + CNT_ONE;
      end
    end

    assign stable[i] = level;
  end

  assign press = stable & ~stable_d;

  // --------------------------------------------------------------------------
  // Direction arbitration: the lowest index wins, losers are dropped.
  // --------------------------------------------------------------------------
  always_comb begin
    dir_hit = |press[3:0];
    dir_sel = 2'd0;
    if (press[0]) begin
      dir_sel = 2'd0;
    end else if (press[1]) begin
      dir_sel = 2'd1;
    end else if (press[2]) begin
      dir_sel = 2'd2;
    end else if (press[3]) begin
      dir_sel = 2'd3;
    end
  end

  assign active_held = stable[active];

  // --------------------------------------------------------------------------
  // Auto-repeat FSM with registered outputs. An accepted press always wins
  // over a repeat that happens to be due in the same cycle, and a dropped
  // active level is checked before the repeat so that a release landing on
  // a repeat cycle suppresses it.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state   <= IDLE;
      active  <= 2'd0;
      rep_cnt <= '0;
      dir_q   <= 3'd0;
      move_q  <= 1'b0;
    end else begin
      dir_q  <= 3'd0;
      move_q <= press[4];

      if (dir_hit) begin
        dir_q   <= dir_code(dir_sel);
        active  <= dir_sel;
        state   <= DELAY;
        rep_cnt <= '0;
      end else begin
        case (state)
          IDLE: begin
            state <= IDLE;
          end

          DELAY: begin
            if (!active_held) begin
              state <= IDLE;
            end else if (rep_cnt == DLY_LAST) begin
              dir_q   <= dir_code(active);
              state   <= REPEAT;
              rep_cnt <= '0;
            end else begin
              rep_cnt <= rep_cnt + CNT_ONE;
            end
          end

          REPEAT: begin
            if (!active_held) begin
              state <= IDLE;
            end else if (rep_cnt == PER_LAST) begin
              dir_q   <= dir_code(active);
              rep_cnt <= '0;
            end else begin
              rep_cnt <= rep_cnt + CNT_ONE;
            end
          end

          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

  assign bus.dir         = dir_q;
  assign bus.move        = move_q;
  assign bus.keys_stable = stable;

endmodule
`default_nettype wire

// File: tb/tb_key_input_conditioner.sv
`default_nettype none
// ============================================================================
// tb_key_input_conditioner
// ----------------------------------------------------------------------------
// Self-checking bench for key_input_conditioner with DEBOUNCE_CYCLES=4,
// REPEAT_DELAY=10, REPEAT_PERIOD=3. A cycle-level reference model derived
// from the behavioural rules (consecutive-cycle debounce, press = new stable
// high, repeat times from elapsed cycles since the accepted press) is
// compared against every output on every cycle; a vector table and a few
// hand-written scenarios check exact pulse counts and positions.
//
// Revision: 1.0 - initial release
// ============================================================================
module tb_key_input_conditioner;

  localparam int D  = 4;
  localparam int RD = 10;
  localparam int RP = 3;

  logic       clk = 1'b0;
  logic       resetn;
  logic [4:0] keys;   // {place,left,right,down,up}

  key_input_conditioner_if bus ();

  assign bus.key_up    = keys[0];
  assign bus.key_down  = keys[1];
  assign bus.key_right = keys[2];
  assign bus.key_left  = keys[3];
  assign bus.key_place = keys[4];

  key_input_conditioner #(
    .DEBOUNCE_CYCLES (D),
    .REPEAT_DELAY    (RD),
    .REPEAT_PERIOD   (RP),
    .CNT_W           (8)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // --------------------------------------------------------------------------
  // Reference model, updated on each rising edge from the pre-edge inputs.
  // --------------------------------------------------------------------------
  logic [4:0] m_s1, m_s2, m_stable, m_prev;
  int         m_run [5];
  int         act = -1;
  int         t_press = 0;
  logic [2:0] e_dir = 3'd0;
  logic       e_move = 1'b0;
  bit         mvalid = 1'b0;

  always @(posedge clk) begin
    logic [4:0] pr;
    int         k;
    int         dt;
    cyc++;
    if (!resetn) begin
      m_s1 = '0; m_s2 = '0; m_stable = '0; m_prev = '0;
      for (int i = 0; i < 5; i++) m_run[i] = 0;
      act = -1; e_dir = 3'd0; e_move = 1'b0; mvalid = 1'b1;
    end else begin
      pr     = m_stable & ~m_prev;
      e_move = pr[4];
      e_dir  = 3'd0;
      k      = -1;
      for (int i = 3; i >= 0; i--) if (pr[i]) k = i;
      if (k >= 0) begin
        act = k; t_press = cyc; e_dir = 3'(k + 1);
      end else if (act >= 0) begin
        dt = cyc - t_press;
        if (!m_stable[act]) act = -1;
        else if (dt >= RD && (dt - RD) % RP == 0) e_dir = 3'(act + 1);
      end
      m_prev = m_stable;
      for (int i = 0; i < 5; i++) begin
        if (m_s2[i] !== m_stable[i]) begin
          m_run[i]++;
          if (m_run[i] == D) begin
            m_stable[i] = m_s2[i];
            m_run[i]    = 0;
          end
        end else begin
          m_run[i] = 0;
        end
      end
      m_s2 = m_s1;
      m_s1 = keys;
    end
  end

  // Pulse logs for position checks.
  int         log_cyc [$];
  logic [2:0] log_code[$];
  int         mv_cyc  [$];

  always @(negedge clk) begin
    if (mvalid) begin
      check("model_dir",  32'(bus.dir),         32'(e_dir));
      check("model_move", 32'(bus.move),        32'(e_move));
      check("model_keys", 32'(bus.keys_stable), 32'(m_stable));
      if (bus.dir !== 3'd0) begin
        log_cyc.push_back(cyc);
        log_code.push_back(bus.dir);
      end
      if (bus.move === 1'b1) mv_cyc.push_back(cyc);
    end
  end

  task automatic run(input logic [4:0] k, input int n);
    keys = k;
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_logs();
    log_cyc.delete(); log_code.delete(); mv_cyc.delete();
  endtask

  int e_off[$];
  int e_code[$];
  int em_off[$];

  task automatic compare_log(input string name, input int c0);
    check({name, "_dir_count"}, 32'(log_cyc.size()), 32'(e_off.size()));
    for (int i = 0; i < log_cyc.size() && i < e_off.size(); i++) begin
      check({name, "_dir_when"}, 32'(log_cyc[i] - c0), 32'(e_off[i]));
      check({name, "_dir_code"}, 32'(log_code[i]),     32'(e_code[i]));
    end
    check({name, "_move_count"}, 32'(mv_cyc.size()), 32'(em_off.size()));
    for (int i = 0; i < mv_cyc.size() && i < em_off.size(); i++)
      check({name, "_move_when"}, 32'(mv_cyc[i] - c0), 32'(em_off[i]));
  endtask

  typedef struct {
    logic [4:0] keys;
    int         hold;
    int         code;
    int         ndir;
    int         nmove;
  } vec_t;

  vec_t tbl [10];

  initial begin
    int c0;
    int bad;

    // {keys, hold cycles, expected code, dir pulses, move pulses}
    tbl[0] = '{5'b00001,  5, 1, 1, 0};
    tbl[1] = '{5'b00010,  3, 2, 0, 0};   // one cycle too short to debounce
    tbl[2] = '{5'b00100,  4, 3, 1, 0};   // exactly DEBOUNCE_CYCLES
    tbl[3] = '{5'b01000, 13, 4, 2, 0};   // release lands on second repeat
    tbl[4] = '{5'b01000, 14, 4, 3, 0};
    tbl[5] = '{5'b10000, 20, 0, 0, 1};
    tbl[6] = '{5'b00011,  5, 1, 1, 0};
    tbl[7] = '{5'b01110,  5, 2, 1, 0};
    tbl[8] = '{5'b01100,  5, 3, 1, 0};
    tbl[9] = '{5'b11000,  5, 4, 1, 1};

    // Reset with all keys held.
    resetn = 1'b0;
    keys   = 5'h1f;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      check("reset_outputs", 32'({bus.dir, bus.move, bus.keys_stable}), 32'd0);
    end
    clear_logs();
    c0 = cyc;
    resetn = 1'b1;
    run(5'h1f, 12);
    run(5'h00, 15);
    e_off = '{7, 17}; e_code = '{1, 1}; em_off = '{7};
    compare_log("reset_release", c0);

    // Vector table.
    for (int v = 0; v < 10; v++) begin
      clear_logs();
      c0 = cyc;
      run(tbl[v].keys, tbl[v].hold);
      run(5'h00, 25);
      bad = 0;
      foreach (log_code[i]) if (32'(log_code[i]) != 32'(tbl[v].code)) bad++;
      check("table_dir_count",  32'(log_cyc.size()), 32'(tbl[v].ndir));
      check("table_wrong_code", 32'(bad),            32'd0);
      check("table_move_count", 32'(mv_cyc.size()),  32'(tbl[v].nmove));
      if (tbl[v].ndir > 0 && log_cyc.size() > 0)
        check("table_first_when", 32'(log_cyc[0] - c0), 32'd7);
    end

    // Bounce on press and on release.
    clear_logs();
    run(5'b00100, 1); run(5'b00000, 1); run(5'b00100, 1); run(5'b00000, 1);
    c0 = cyc;
    run(5'b00100, 5);
    run(5'b00000, 1); run(5'b00100, 1); run(5'b00000, 1); run(5'b00100, 1);
    run(5'b00000, 20);
    e_off = '{7}; e_code = '{3}; em_off.delete();
    compare_log("bounce", c0);

    // Held Down auto-repeat.
    clear_logs(); c0 = cyc;
    run(5'b00010, 37);
    run(5'b00000, 15);
    e_off  = '{7, 17, 20, 23, 26, 29, 32, 35, 38, 41};
    e_code = '{2, 2, 2, 2, 2, 2, 2, 2, 2, 2};
    em_off.delete();
    compare_log("repeat", c0);

    // Simultaneous Up and Left; releasing Up does not reveal Left.
    clear_logs(); c0 = cyc;
    run(5'b01001, 20);
    run(5'b01000, 20);
    run(5'b00000, 15);
    e_off = '{7, 17, 20, 23, 26}; e_code = '{1, 1, 1, 1, 1}; em_off.delete();
    compare_log("simultaneous", c0);

    // Right overrides Down in REPEAT.
    clear_logs(); c0 = cyc;
    run(5'b00010, 18);
    run(5'b00110, 18);
    run(5'b00000, 15);
    e_off  = '{7, 17, 20, 23, 25, 35, 38, 41};
    e_code = '{2, 2, 2, 2, 3, 3, 3, 3};
    em_off.delete();
    compare_log("override", c0);

    // Place press landing on an Up repeat cycle; move does not repeat.
    clear_logs(); c0 = cyc;
    run(5'b00001, 16);
    run(5'b10001, 14);
    run(5'b10000, 10);
    run(5'b00000, 15);
    e_off  = '{7, 17, 20, 23, 26, 29, 32, 35};
    e_code = '{1, 1, 1, 1, 1, 1, 1, 1};
    em_off = '{23};
    compare_log("place_on_repeat", c0);

    // Randomised stimulus against the reference model, with occasional resets.
    for (int it = 0; it < 150; it++) begin
      if ($urandom_range(0, 39) == 0) begin
        resetn = 1'b0;
        run(keys, int'($urandom_range(1, 3)));
        resetn = 1'b1;
      end
      run(5'($urandom), int'($urandom_range(1, 24)));
    end
    run(5'b00000, 30);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/key_input_conditioner.md
# key_input_conditioner

Front-end stage of the tic-tac-toe design. It turns the five raw push-button inputs (up, down, right, left, place) into the clean one-cycle command codes that the cursor control unit consumes: a `dir` code and a `move` strobe. It sits between the board's key pins (already inverted to active-high at top level) and the cursor/grid control logic. Each raw input is synchronised and debounced, press events are detected and arbitrated, and a held direction key auto-repeats.

## Interface
- `DEBOUNCE_CYCLES`, default 500000: consecutive cycles a synchronised key must differ from its stable value before the stable value flips (10 ms at 50 MHz); minimum 2.
- `REPEAT_DELAY`, default 25000000: cycles from the initial direction pulse to the first repeat pulse; minimum 2.
- `REPEAT_PERIOD`, default 10000000: cycles between subsequent repeat pulses; minimum 2.
- `CNT_W`, default 25: width of the debounce and repeat counters; must hold the largest of the three values above.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `resetn`  in  1  reset, synchronous, active-low.
- `key_up`, `key_down`, `key_right`, `key_left`, `key_place`  in  1 each  raw, asynchronous, active-high, bouncing.
- `dir`  out  3  registered command: Idle=000, Up=001, Down=010, Right=011, Left=100; non-Idle for exactly one cycle per event.
- `move`  out  1  registered one-cycle place strobe.
- `keys_stable`  out  5  debounced levels {place,left,right,down,up}, for debug LEDs.

## Operation
- Synchroniser: two flops per key; only the second flop's output is used downstream.
- Debounce, per key:
  - When the synced value equals the stable value, the counter clears.
  - Otherwise the counter increments. On the cycle it would reach `DEBOUNCE_CYCLES`, the stable value takes the synced value and the counter clears.
  - A glitch shorter than `DEBOUNCE_CYCLES` never changes the stable value.
- Press event: a 0→1 transition of a stable level. Release events produce no output.
- Direction arbitration:
  - If several direction press events occur in the same cycle, the priority is Up > Down > Right > Left.
  - Losing events are discarded, not queued.
  - The accepted key becomes the active key.
- Repeat FSM, with states IDLE, DELAY and REPEAT, and one repeat counter:
  - IDLE: on an accepted press, emit its code, go to DELAY and clear the counter.
  - DELAY: if the active key's stable level drops, go to IDLE and emit nothing. Otherwise, when the counter reaches `REPEAT_DELAY-1`, emit the active code, go to REPEAT and clear the counter.
  - REPEAT: if the active key is released, go to IDLE. Otherwise, every time the counter reaches `REPEAT_PERIOD-1`, emit the active code and clear the counter.
  - A new accepted press in DELAY or REPEAT (a different key, or the same key after release and re-press) emits the new code, replaces the active key, goes to DELAY and clears the counter. This takes precedence over any repeat due in the same cycle.
  - Pressing a non-active direction key while the active key is held does not change the FSM unless that key's own press event is accepted.
- Place: a press event on `key_place` gives one `move` pulse and never repeats. `move` is independent of `dir`; both may assert in the same cycle.
- Reset:
  - Synchroniser flops, stable levels, all counters: 0. FSM: IDLE. `dir`=000, `move`=0, `keys_stable`=00000.
  - A key held through reset release is treated as a new press once its debounce completes.

## Timing
- Raw rise first sampled at edge N and held: the stable level is 1 after edge N+1+`DEBOUNCE_CYCLES`. The `dir`/`move` pulse is visible after edge N+2+`DEBOUNCE_CYCLES`, for one cycle.
- Initial pulse at cycle P: the first repeat is at P+`REPEAT_DELAY` and subsequent repeats are at intervals of `REPEAT_PERIOD`.
- A release whose stable fall lands in the same cycle a repeat is due suppresses that repeat.
- Maximum `dir` rate is one event per cycle. There is no handshake; the consumer samples every cycle.

## Test plan
All tests use `DEBOUNCE_CYCLES`=4, `REPEAT_DELAY`=10, `REPEAT_PERIOD`=3.
- Reset: hold `resetn`=0 for 3 cycles with all keys high, then release. All outputs stay 0 during reset. A single `move` pulse and `dir`=001 occur 6 cycles after release, followed by Up repeats.
- Bounce: toggle `key_right` 1,0,1,0 on successive cycles, then hold 1. No pulse during the bouncing. Exactly one `dir`=011 appears 6 cycles after the hold starts. No second pulse when the key bounces on release.
- Repeat: hold `key_down` for 30 cycles after its debounce. Pulses of 010 appear at P, P+10, P+13, P+16, P+19 and so on. After release, no further pulse appears.
- Simultaneous: raise `key_left` and `key_up` on the same edge and hold both. Only 001 pulses appear, including repeats. Release `key_up`: repeats stop, and no Left pulse appears.
- Override: while Down is in REPEAT, press Right. Right is emitted once. Its first repeat comes 10 cycles later, and no further Down pulses appear.
- Place during repeat: press `key_place` in the cycle an Up repeat is due. `move`=1 and `dir`=001 appear in the same cycle. `move` does not repeat while held.
